// File: rtl/led_nios_key_pio_if.sv
`default_nettype none
// ============================================================================
// Module   : led_nios_key_pio_if
// Purpose  : Avalon-MM zero-wait, zero-read-latency slave bus bundle for the
//            key input PIO.
// Signals  : address[1:0] word address, chipselect slave select,
//            write_n active-low write strobe, writedata[31:0] write data,
//            readdata[31:0] combinational read data (driven by the slave).
// Revision : 1.0 - initial release
// ============================================================================
interface led_nios_key_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface
`default_nettype wire

// File: rtl/led_nios_key_pio.sv
`default_nettype none
// ============================================================================
// Module   : led_nios_key_pio
// Purpose  : Avalon-MM input PIO for push-button keys. Raw key lines are
//            synchronized (2 FF), debounced per bit, edge-detected into a
//            sticky write-1-to-clear capture register, and combined with a
//            per-bit mask into a level interrupt.
// Ports    : clk      system clock
//            reset_n  asynchronous active-low reset
//            bus      Avalon-MM slave (address/chipselect/write_n/
//                     writedata/readdata)
//            in_port  raw asynchronous key inputs [WIDTH-1:0]
//            irq      level interrupt, |(edgecapture & interruptmask)
// Register : 0 data (RO), 1 reads 0, 2 interruptmask (RW),
//            3 edgecapture (read / write-1-to-clear)
// Revision : 1.0 - initial release
// ============================================================================
module led_nios_key_pio #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = {WIDTH{1'b1}}
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  led_nios_key_pio_if.slave     bus,
  input  wire logic [WIDTH-1:0] in_port,
  output logic                  irq
);

  localparam int             CNT_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]     C_ADDR_DATA = 2'd0;
  localparam logic [1:0]     C_ADDR_MASK = 2'd2;
  localparam logic [1:0]     C_ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_stable_d;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;

  logic [WIDTH-1:0] w_accept;
  logic [WIDTH-1:0] w_event;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;
  logic [31:0]      w_rdata;

  // --------------------------------------------------------------------------
  // Synchronizer, stable level and its delayed copy for edge detection.
  // Reset loads RESET_LEVEL into all of them so release creates no edge.
  // An accepted bit always differs from sync2, so acceptance is a flip.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1    <= RESET_LEVEL;
      r_sync2    <= RESET_LEVEL;
      r_stable   <= RESET_LEVEL;
      r_stable_d <= RESET_LEVEL;
    end else begin
      r_sync1    <= in_port;
      r_sync2    <= r_sync1;
      r_stable   <= r_stable ^ w_accept;
      r_stable_d <= r_stable;
    end
  end

  // --------------------------------------------------------------------------
  // Per-bit debounce counter. Counts cycles that sync2 disagrees with the
  // stable level; any return to agreement discards the pending change.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_deb
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;
    logic             w_done;

    assign w_diff       = r_sync2[gi] ^ r_stable[gi];
    assign w_done       = w_diff && (r_cnt == C_CNT_MAX);
    assign w_accept[gi] = w_done;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt <= '0;
      end else if (!w_diff || w_done) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Edge event selection.
  // --------------------------------------------------------------------------
  if (EDGE_TYPE == 0) begin : g_rise
    assign w_event = r_stable & ~r_stable_d;
  end else if (EDGE_TYPE == 1) begin : g_fall
    assign w_event = ~r_stable & r_stable_d;
  end else begin : g_any
    assign w_event = r_stable ^ r_stable_d;
  end

  // --------------------------------------------------------------------------
  // Register writes. Set beats clear when both hit a capture bit together.
  // --------------------------------------------------------------------------
  assign w_wr  = bus.chipselect && !bus.write_n;
  assign w_clr = (w_wr && (bus.address == C_ADDR_EDGE)) ? bus.writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
      r_cap  <= '0;
    end else begin
      if (w_wr && (bus.address == C_ADDR_MASK)) begin
        r_mask <= bus.writedata[WIDTH-1:0];
      end
      r_cap <= w_event | (r_cap & ~w_clr);
    end
  end

  // Writedata bits above WIDTH have no register behind them.
  if (WIDTH < 32) begin : g_wd_pad
    logic w_unused_wd;
    assign w_unused_wd = ^bus.writedata[31:WIDTH];
  end

  // --------------------------------------------------------------------------
  // Combinational read mux; unused upper bits and address 1 read zero.
  // --------------------------------------------------------------------------
  always_comb begin
    w_rdata = '0;
    case (bus.address)
      C_ADDR_DATA: w_rdata[WIDTH-1:0] = r_stable;
      C_ADDR_MASK: w_rdata[WIDTH-1:0] = r_mask;
      C_ADDR_EDGE: w_rdata[WIDTH-1:0] = r_cap;
      default:     w_rdata            = '0;
    endcase
  end

  assign bus.readdata = w_rdata;
  assign irq          = |(r_cap & r_mask);

endmodule
`default_nettype wire

// File: doc/led_nios_key_pio.md
# led_nios_key_pio

Avalon-MM slave input port for the Nios II system: the read-side counterpart of the LED output PIO. It brings WIDTH asynchronous push-button lines into the `clk` domain through a 2-FF synchronizer and a per-bit debouncer. It records debounced edges in a sticky edge-capture register and raises a level interrupt to the Nios II CPU through a per-bit mask. Register access uses the same zero-wait, zero-read-latency slave protocol as the LED PIO.

## Interface
- WIDTH, 4: number of input lines (1..32).
- DEBOUNCE_CYCLES, 50000: consecutive `clk` cycles a synchronized level must differ from the stable level before it is accepted (≥1; 1 ms at 50 MHz).
- EDGE_TYPE, 1: edge type captured; 0 = rising, 1 = falling, 2 = any.
- RESET_LEVEL, {WIDTH{1'b1}}: reset value of the synchronizer and stable level (keys are active-low).

- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- address  in  2  word address of the register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data; combinational from address.
- in_port  in  WIDTH  raw asynchronous key inputs.
- irq  out  1  level interrupt to the CPU.

## Operation
- Register map:
  - 0 data: RO; debounced stable level; writes are ignored.
  - 1: reads 0; writes are ignored.
  - 2 interruptmask: RW, WIDTH bits.
  - 3 edgecapture: read returns the capture bits; a write of 1 to a bit clears that bit, and a write of 0 leaves it unchanged.
- readdata bits [31:WIDTH] always read 0.
- A write occurs when chipselect && !write_n. There are no wait states and no read strobe, so reads have no side effects.
- Synchronizer: sync1 <= in_port, sync2 <= sync1.
- Debouncer, per bit: cnt is sized by $clog2(DEBOUNCE_CYCLES) with a minimum of 1 bit.
  - sync2 == stable: cnt <= 0.
  - sync2 != stable and cnt < DEBOUNCE_CYCLES-1: cnt++.
  - sync2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and cnt <= 0.
  - Any return to equality before acceptance discards the pending change; the counter never wraps.
- Edge detect: stable_d <= stable. The per-bit event is:
  - EDGE_TYPE 0: stable & ~stable_d.
  - EDGE_TYPE 1: ~stable & stable_d.
  - EDGE_TYPE 2: stable ^ stable_d.
- Edge-capture update, per bit, in one clock: capture <= event | (capture & ~clear). If a clear and an event coincide, the set wins.
- irq = |(edgecapture & interruptmask), combinational from registers. Writing the mask can therefore raise irq for an already-captured bit.
- Reset, asynchronous and valid at any time, including mid-debounce:
  - sync1, sync2, stable and stable_d go to RESET_LEVEL.
  - cnt, interruptmask and edgecapture go to 0.
  - irq goes to 0.
  - readdata follows the register values for the current address.
  - No edge is generated on reset release.

## Timing
- Suppose in_port[i] changes before edge k and then holds. The path through the logic is:
  - sync2 changes at edge k+1.
  - stable changes at edge k+1+DEBOUNCE_CYCLES.
  - edgecapture[i] sets at edge k+2+DEBOUNCE_CYCLES.
  - irq is high in the following cycle if the bit is masked in.
- A pulse that holds sync2 for fewer than DEBOUNCE_CYCLES cycles never changes stable.
- A register write takes effect at the clock edge where it is sampled. A read in the following cycle returns the new value.
- A clear of edgecapture drops irq in the cycle after the write edge, unless another masked capture bit is set.

## Test plan
- Reset: hold reset_n low with in_port = 4'hF. Required: data reads 0x0000000F, mask reads 0, edgecapture reads 0, irq = 0. Releasing reset produces no capture.
- Debounce timing (DEBOUNCE_CYCLES=4): drive in_port[0] 1→0 before edge k. Required: data reads 0xE from the cycle after edge k+5, edgecapture reads 0x1 after edge k+6, and irq stays 0 while the mask is 0.
- Glitch rejection (DEBOUNCE_CYCLES=4): a 3-cycle low pulse on in_port[2] leaves data at 0xF and edgecapture at 0, and cnt returns to 0. A 4-cycle low pulse is accepted, capturing bit 2.
- IRQ and clear: write mask = 0x1 with edgecapture = 0x1, so irq rises. Write 0x1 to address 3: irq falls and edgecapture reads 0. Writing 0x0 to address 3 has no effect.
- Simultaneous clear and set: issue the write-1-to-clear on address 3 in the same cycle that a new falling event on bit 0 is detected. Required: edgecapture[0] stays 1 and irq stays high.
- EDGE_TYPE=2 and address decode: a press followed by a release, cleared between them, captures the bit twice. Writes to addresses 0 and 1 change nothing. Address 1 reads 0, and bits [31:4] always read 0.
